// File: rtl/rvfi_buf_pkg.sv
// Shared types for the RVFI retire buffer.
// rvfi_pkt_t is one retired-instruction packet (NRET=1, XLEN=32) as stored in the FIFO
// and presented on the output stream. PKT_W is its flattened width.
package rvfi_buf_pkg;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
  } rvfi_pkt_t;

  localparam int unsigned PKT_W = $bits(rvfi_pkt_t);

endpackage

// File: rtl/rvfi_sync_fifo.sv
// Single-clock FIFO with registered storage.
// Pointers carry an extra wrap bit so full and empty are distinguishable without a counter.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i, wdata_i write strobe and data (caller guarantees !full or simultaneous pop)
//   pop_i           read strobe (caller guarantees !empty)
//   rdata_o         head entry, zero while empty
//   full_o, empty_o occupancy flags
//   level_o         current occupancy, 0..DEPTH
module rvfi_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: nothing is visible until a pointer has advanced past it.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  always_comb begin
    empty_o = (wr_ptr_q == rd_ptr_q);
    full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    level_o = wr_ptr_q - rd_ptr_q;
    rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

endmodule

// File: rtl/rvfi_retire_buffer.sv
// Captures RVFI retirement packets into a FIFO and replays them on a valid/ready stream.
// Also checks retirement-order continuity and x0 writes, keeping sticky status.
// Ports:
//   clk, rst_l           clock, asynchronous active-low reset
//   rvfi_*               retirement port (NRET=1, XLEN=32)
//   out_valid/out_ready  output stream handshake; out_pkt is the head packet
//   level                FIFO occupancy
//   overflow, order_err, x0_err  sticky error flags
//   err_order            rvfi_order of the first order error
//   drop_cnt             saturating count of discarded packets
//   clear                synchronous clear of flags, err_order and drop_cnt
module rvfi_retire_buffer
  import rvfi_buf_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DCNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   rvfi_valid,
  input  logic [63:0]            rvfi_order,
  input  logic [31:0]            rvfi_insn,
  input  logic                   rvfi_trap,
  input  logic [31:0]            rvfi_pc_rdata,
  input  logic [31:0]            rvfi_pc_wdata,
  input  logic [4:0]             rvfi_rd_addr,
  input  logic [31:0]            rvfi_rd_wdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PKT_W-1:0]       out_pkt,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   order_err,
  output logic                   x0_err,
  output logic [63:0]            err_order,
  output logic [DCNT_W-1:0]      drop_cnt,
  input  logic                   clear
);

  rvfi_pkt_t in_pkt;
  logic      full, empty, push, pop, drop;
  logic      order_bad, x0_bad;

  logic              overflow_q, overflow_d;
  logic              order_err_q, order_err_d;
  logic              x0_err_q, x0_err_d;
  logic [63:0]       err_order_q, err_order_d;
  logic [DCNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [63:0]       exp_order_q, exp_order_d;

  always_comb begin
    in_pkt.order    = rvfi_order;
    in_pkt.insn     = rvfi_insn;
    in_pkt.trap     = rvfi_trap;
    in_pkt.pc_rdata = rvfi_pc_rdata;
    in_pkt.pc_wdata = rvfi_pc_wdata;
    in_pkt.rd_addr  = rvfi_rd_addr;
    in_pkt.rd_wdata = rvfi_rd_wdata;
  end

  // A full FIFO still accepts a packet when the head leaves in the same cycle.
  always_comb begin
    out_valid = !empty;
    pop       = out_valid && out_ready;
    push      = rvfi_valid && (!full || pop);
    drop      = rvfi_valid && full && !pop;
    order_bad = rvfi_valid && (rvfi_order != exp_order_q);
    x0_bad    = rvfi_valid && (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0);
  end

  rvfi_sync_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_l),
    .push_i  (push),
    .wdata_i (in_pkt),
    .pop_i   (pop),
    .rdata_o (out_pkt),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  // Clear is applied first so a coincident error event overrides it.
  always_comb begin
    overflow_d  = clear ? 1'b0 : overflow_q;
    order_err_d = clear ? 1'b0 : order_err_q;
    x0_err_d    = clear ? 1'b0 : x0_err_q;
    err_order_d = clear ? '0   : err_order_q;
    drop_cnt_d  = clear ? '0   : drop_cnt_q;
    exp_order_d = exp_order_q;

    if (rvfi_valid) exp_order_d = rvfi_order + 64'd1;

    if (order_bad) begin
      order_err_d = 1'b1;
      // Keep the first error; after a clear the slot is free again.
      if (!order_err_q || clear) err_order_d = rvfi_order;
    end

    if (x0_bad) x0_err_d = 1'b1;

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_d != '1) drop_cnt_d = drop_cnt_d + DCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      overflow_q  <= 1'b0;
      order_err_q <= 1'b0;
      x0_err_q    <= 1'b0;
      err_order_q <= '0;
      drop_cnt_q  <= '0;
      exp_order_q <= '0;
    end else begin
      overflow_q  <= overflow_d;
      order_err_q <= order_err_d;
      x0_err_q    <= x0_err_d;
      err_order_q <= err_order_d;
      drop_cnt_q  <= drop_cnt_d;
      exp_order_q <= exp_order_d;
    end
  end

  always_comb begin
    overflow  = overflow_q;
    order_err = order_err_q;
    x0_err    = x0_err_q;
    err_order = err_order_q;
    drop_cnt  = drop_cnt_q;
  end

endmodule
